// File: rtl/aibcr3_dcc_cal_ctrl.sv
// rtl/aibcr3_dcc_cal_ctrl.sv - DCC calibration sequencer: request low-hold, timed attempts,
// bounded retries, lock/lost-lock/fail status with registered outputs.
module aibcr3_dcc_cal_ctrl #(
  parameter int LOW_CYC   = 8,
  parameter int TO_W      = 16,
  parameter int MAX_RETRY = 3,
  parameter int RW        = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cal_start,
  input  logic            cal_stop,
  input  logic            cal_bypass,
  input  logic [TO_W-1:0] timeout_val,
  input  logic            dcc_done,
  output logic            dcc_req,
  output logic            cal_done,
  output logic            cal_err,
  output logic            cal_busy,
  output logic [RW-1:0]   retry_cnt,
  output logic            lock_lost
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOWHOLD   = 3'd1,
    WAIT_DONE = 3'd2,
    LOCKED    = 3'd3,
    FAIL      = 3'd4
  } state_t;

  localparam logic [TO_W-1:0] ONE        = TO_W'(1);
  localparam logic [TO_W-1:0] LOW_MAX    = TO_W'(LOW_CYC);
  localparam logic [TO_W-1:0] LOW_LAST   = TO_W'(LOW_CYC - 1);
  localparam logic [RW-1:0]   RETRY_LAST = RW'(MAX_RETRY);
  localparam logic [RW-1:0]   RETRY_ONE  = RW'(1);

  state_t          state, state_nx;
  logic [TO_W-1:0] cnt, cnt_nx;
  logic [RW-1:0]   retry_nx;
  logic            bypass, bypass_nx;
  logic            lock_lost_nx;
  logic            sync_q, done_s;
  logic            timeout_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 1'b0;
      done_s <= 1'b0;
    end else begin
      sync_q <= dcc_done;
      done_s <= sync_q;
    end
  end

  assign timeout_hit = (timeout_val != '0) && (cnt == timeout_val - ONE);

  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    retry_nx     = retry_cnt;
    lock_lost_nx = lock_lost;
    bypass_nx    = bypass;
    if (cal_stop) begin
      state_nx = IDLE;
      cnt_nx   = '0;
    end else begin
      case (state)
        IDLE, FAIL: begin
          if (cal_start) begin
            bypass_nx = cal_bypass;
            cnt_nx    = '0;
            if (cal_bypass) begin
              state_nx = LOCKED;
            end else begin
              state_nx     = LOWHOLD;
              retry_nx     = '0;
              lock_lost_nx = 1'b0;
            end
          end
        end
        LOWHOLD: begin
          // A stuck-high done_s parks us here with cnt saturated; no timeout applies.
          if ((cnt >= LOW_LAST) && !done_s) begin
            state_nx = WAIT_DONE;
            cnt_nx   = '0;
          end else if (cnt < LOW_MAX) begin
            cnt_nx = cnt + ONE;
          end
        end
        WAIT_DONE: begin
          if (done_s) begin
            state_nx = LOCKED;
            cnt_nx   = '0;
          end else if (timeout_hit) begin
            cnt_nx = '0;
            if (retry_cnt == RETRY_LAST) begin
              state_nx = FAIL;
            end else begin
              state_nx = LOWHOLD;
              retry_nx = retry_cnt + RETRY_ONE;
            end
          end else begin
            cnt_nx = cnt + ONE;
          end
        end
        LOCKED: begin
          // Losing lock grants a fresh attempt budget.
          if (!bypass && !done_s) begin
            state_nx     = LOWHOLD;
            cnt_nx       = '0;
            retry_nx     = '0;
            lock_lost_nx = 1'b1;
          end
        end
        default: begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state and registered so they leave flops directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      retry_cnt <= '0;
      lock_lost <= 1'b0;
      bypass    <= 1'b0;
      dcc_req   <= 1'b0;
      cal_done  <= 1'b0;
      cal_err   <= 1'b0;
      cal_busy  <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      retry_cnt <= retry_nx;
      lock_lost <= lock_lost_nx;
      bypass    <= bypass_nx;
      dcc_req   <= (state_nx == WAIT_DONE) || ((state_nx == LOCKED) && !bypass_nx);
      cal_done  <= (state_nx == LOCKED);
      cal_err   <= (state_nx == FAIL);
      cal_busy  <= (state_nx == LOWHOLD) || (state_nx == WAIT_DONE);
    end
  end

endmodule

// File: tb/tb_aibcr3_dcc_cal_ctrl.sv
// tb/tb_aibcr3_dcc_cal_ctrl.sv - self-checking bench for aibcr3_dcc_cal_ctrl with a DCC macro model
// and event-time predictions computed from the sequencing rules.
module tb_aibcr3_dcc_cal_ctrl;
  localparam int LOW_CYC   = 8;
  localparam int TO_W      = 16;
  localparam int MAX_RETRY = 3;
  localparam int RW        = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            cal_start = 1'b0;
  logic            cal_stop = 1'b0;
  logic            cal_bypass = 1'b0;
  logic [TO_W-1:0] timeout_val = '0;
  logic            dcc_done;
  logic            dcc_req, cal_done, cal_err, cal_busy, lock_lost;
  logic [RW-1:0]   retry_cnt;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  aibcr3_dcc_cal_ctrl #(.LOW_CYC(LOW_CYC), .TO_W(TO_W), .MAX_RETRY(MAX_RETRY), .RW(RW)) dut (
    .clk(clk), .rst_n(rst_n), .cal_start(cal_start), .cal_stop(cal_stop),
    .cal_bypass(cal_bypass), .timeout_val(timeout_val), .dcc_done(dcc_done),
    .dcc_req(dcc_req), .cal_done(cal_done), .cal_err(cal_err), .cal_busy(cal_busy),
    .retry_cnt(retry_cnt), .lock_lost(lock_lost)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // DCC macro: answers the k-th request after resp_q[k] cycles (-1 or empty = never);
  // done is forced low whenever the request is low.
  int   resp_q[$];
  int   cur_delay = -1;
  int   age = 0;
  logic mac_up = 1'b0;
  logic mac_drop = 1'b0;
  logic prev_req = 1'b0;
  assign dcc_done = dcc_req & mac_up & ~mac_drop;

  int   req_rise[$], req_fall[$], done_rise[$], busy_fall[$], err_rise[$];
  logic p_done = 1'b0, p_busy = 1'b0, p_err = 1'b0;

  always @(posedge clk) begin
    #1;
    if (dcc_req && !prev_req) req_rise.push_back(cyc);
    if (!dcc_req && prev_req) req_fall.push_back(cyc);
    if (cal_done && !p_done) done_rise.push_back(cyc);
    if (!cal_busy && p_busy) busy_fall.push_back(cyc);
    if (cal_err && !p_err) err_rise.push_back(cyc);
    p_done = cal_done;
    p_busy = cal_busy;
    p_err  = cal_err;
    if (dcc_req && !prev_req) begin
      cur_delay = (resp_q.size() > 0) ? resp_q.pop_front() : -1;
      age = 0;
    end else if (dcc_req) begin
      age++;
    end
    prev_req = dcc_req;
    mac_up = dcc_req && (cur_delay >= 0) && (age >= cur_delay);
  end

  function automatic int at(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_log();
    req_rise.delete(); req_fall.delete(); done_rise.delete();
    busy_fall.delete(); err_rise.delete();
  endtask

  task automatic start_cal(input logic byp, output int s);
    cal_bypass = byp;
    cal_start  = 1'b1;
    tick();
    s = cyc;
    cal_start  = 1'b0;
    cal_bypass = 1'b0;
  endtask

  task automatic stop_cal();
    cal_stop = 1'b1;
    tick();
    cal_stop = 1'b0;
    resp_q.delete();
    mac_drop = 1'b0;
    ticks(3);
  endtask

  task automatic wait_for(input int which, input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound && !ok; i++) begin
      case (which)
        0:       ok = (cal_done === 1'b1);
        1:       ok = (cal_err === 1'b1);
        default: ok = (dcc_req === 1'b1);
      endcase
      if (!ok) tick();
    end
  endtask

  task automatic test_reset();
    ticks(3);
    checks++;
    if ({dcc_req, cal_done, cal_err, cal_busy, lock_lost, retry_cnt} !== 7'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b want 0", {dcc_req, cal_done, cal_err, cal_busy, lock_lost, retry_cnt});
    end
    rst_n = 1'b1;
    ticks(3);
    checks++;
    if ({dcc_req, cal_done, cal_err, cal_busy} !== 4'b0) begin
      errors++;
      $display("FAIL idle_after_reset: got %b want 0", {dcc_req, cal_done, cal_err, cal_busy});
    end
  endtask

  task automatic test_normal_lock();
    int s, d;
    bit ok;
    for (int it = 0; it < 4; it++) begin
      d = (it == 0) ? 20 : $urandom_range(1, 90);
      timeout_val = TO_W'(100);
      clear_log();
      resp_q.push_back(d);
      start_cal(1'b0, s);
      wait_for(0, 400, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL lock_wait: cal_done never rose (d=%0d)", d); end
      checks++;
      if (at(req_rise, 0) !== s + LOW_CYC) begin
        errors++; $display("FAIL req_rise: got %0d want %0d", at(req_rise, 0), s + LOW_CYC);
      end
      checks++;
      if (at(done_rise, 0) !== s + LOW_CYC + d + 3) begin
        errors++; $display("FAIL done_rise: got %0d want %0d", at(done_rise, 0), s + LOW_CYC + d + 3);
      end
      checks++;
      if (at(busy_fall, 0) !== s + LOW_CYC + d + 3) begin
        errors++; $display("FAIL busy_fall: got %0d want %0d", at(busy_fall, 0), s + LOW_CYC + d + 3);
      end
      checks++;
      if (retry_cnt !== RW'(0) || dcc_req !== 1'b1) begin
        errors++; $display("FAIL lock_state: retry=%0d req=%b want retry=0 req=1", retry_cnt, dcc_req);
      end
      stop_cal();
    end
  endtask

  task automatic test_retry_then_lock();
    int s, d, n;
    int exp_r[3];
    int exp_f[2];
    bit ok;
    n = 50;
    d = $urandom_range(1, 40);
    timeout_val = TO_W'(n);
    clear_log();
    resp_q.push_back(-1); resp_q.push_back(-1); resp_q.push_back(d);
    start_cal(1'b0, s);
    wait_for(0, 500, ok);
    exp_r[0] = s + LOW_CYC;
    for (int i = 0; i < 2; i++) begin
      exp_f[i]     = exp_r[i] + n;
      exp_r[i + 1] = exp_f[i] + LOW_CYC;
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL retry_wait: no lock"); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (at(req_rise, i) !== exp_r[i]) begin
        errors++; $display("FAIL retry_rise%0d: got %0d want %0d", i, at(req_rise, i), exp_r[i]);
      end
    end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (at(req_fall, i) !== exp_f[i]) begin
        errors++; $display("FAIL retry_fall%0d: got %0d want %0d", i, at(req_fall, i), exp_f[i]);
      end
    end
    checks++;
    if (at(done_rise, 0) !== exp_r[2] + d + 3 || retry_cnt !== RW'(2)) begin
      errors++; $display("FAIL retry_lock: done=%0d retry=%0d want done=%0d retry=2",
                         at(done_rise, 0), retry_cnt, exp_r[2] + d + 3);
    end
    stop_cal();
  endtask

  task automatic test_exhaustion();
    int s, n, r;
    bit ok;
    n = $urandom_range(10, 60);
    timeout_val = TO_W'(n);
    clear_log();
    start_cal(1'b0, s);
    wait_for(1, 4 * (n + LOW_CYC) + 50, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL exhaust_wait: cal_err never rose"); end
    checks++;
    if (req_rise.size() !== 4 || req_fall.size() !== 4) begin
      errors++; $display("FAIL exhaust_pulses: got %0d/%0d want 4/4", req_rise.size(), req_fall.size());
    end
    r = s + LOW_CYC;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (at(req_rise, i) !== r || at(req_fall, i) !== r + n) begin
        errors++; $display("FAIL exhaust_pulse%0d: got %0d..%0d want %0d..%0d",
                           i, at(req_rise, i), at(req_fall, i), r, r + n);
      end
      r = r + n + LOW_CYC;
    end
    checks++;
    if (at(err_rise, 0) !== at(req_fall, 3) || dcc_req !== 1'b0 || retry_cnt !== RW'(MAX_RETRY)
        || cal_busy !== 1'b0) begin
      errors++; $display("FAIL exhaust_state: err@%0d req=%b retry=%0d busy=%b want err@fall req=0 retry=3 busy=0",
                         at(err_rise, 0), dcc_req, retry_cnt, cal_busy);
    end
    start_cal(1'b0, s);
    checks++;
    if (cal_err !== 1'b0 || cal_busy !== 1'b1 || retry_cnt !== RW'(0)) begin
      errors++; $display("FAIL exhaust_restart: err=%b busy=%b retry=%0d want 0 1 0", cal_err, cal_busy, retry_cnt);
    end
    stop_cal();
  endtask

  task automatic test_same_cycle();
    int s, n, d2;
    bit ok;
    n = $urandom_range(20, 200);
    timeout_val = TO_W'(n);
    clear_log();
    resp_q.push_back(n - 3);
    start_cal(1'b0, s);
    wait_for(0, n + 40, ok);
    checks++;
    if (!ok || at(done_rise, 0) !== s + LOW_CYC + n || retry_cnt !== RW'(0)) begin
      errors++; $display("FAIL same_cycle_lock: done=%0d retry=%0d want done=%0d retry=0",
                         at(done_rise, 0), retry_cnt, s + LOW_CYC + n);
    end
    stop_cal();
    d2 = $urandom_range(1, 10);
    clear_log();
    resp_q.push_back(n - 2);
    resp_q.push_back(d2);
    start_cal(1'b0, s);
    wait_for(0, 2 * n + 60, ok);
    checks++;
    if (!ok || at(done_rise, 0) !== s + 2 * LOW_CYC + n + d2 + 3 || retry_cnt !== RW'(1)) begin
      errors++; $display("FAIL one_late_timeout: done=%0d retry=%0d want done=%0d retry=1",
                         at(done_rise, 0), retry_cnt, s + 2 * LOW_CYC + n + d2 + 3);
    end
    stop_cal();
  endtask

  task automatic test_lost_lock_bypass();
    int s, c, d2;
    bit ok, bad;
    timeout_val = TO_W'(100);
    clear_log();
    resp_q.push_back($urandom_range(1, 30));
    start_cal(1'b0, s);
    wait_for(0, 200, ok);
    ticks($urandom_range(1, 20));
    d2 = $urandom_range(1, 30);
    resp_q.push_back(d2);
    c = cyc;
    mac_drop = 1'b1;
    ticks(2);
    checks++;
    if (cal_done !== 1'b1 || dcc_req !== 1'b1 || lock_lost !== 1'b0) begin
      errors++; $display("FAIL lost_early: done=%b req=%b lost=%b want 1 1 0", cal_done, dcc_req, lock_lost);
    end
    tick();
    checks++;
    if (cal_done !== 1'b0 || dcc_req !== 1'b0 || lock_lost !== 1'b1 || retry_cnt !== RW'(0)) begin
      errors++; $display("FAIL lost_edge: done=%b req=%b lost=%b retry=%0d want 0 0 1 0",
                         cal_done, dcc_req, lock_lost, retry_cnt);
    end
    mac_drop = 1'b0;
    wait_for(0, 100, ok);
    checks++;
    if (!ok || at(done_rise, 1) !== c + 3 + LOW_CYC + d2 + 3 || lock_lost !== 1'b1) begin
      errors++; $display("FAIL relock: done=%0d lost=%b want done=%0d lost=1",
                         at(done_rise, 1), lock_lost, c + 3 + LOW_CYC + d2 + 3);
    end
    stop_cal();
    start_cal(1'b1, s);
    checks++;
    if (cal_done !== 1'b1 || dcc_req !== 1'b0) begin
      errors++; $display("FAIL bypass_lock: done=%b req=%b want 1 0", cal_done, dcc_req);
    end
    bad = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (dcc_req !== 1'b0 || cal_done !== 1'b1) bad = 1'b1;
      tick();
    end
    checks++;
    if (bad) begin errors++; $display("FAIL bypass_hold: req/done moved got 1 want steady 0/1"); end
    stop_cal();
  endtask

  task automatic test_timeout_zero();
    int s;
    bit bad;
    timeout_val = '0;
    clear_log();
    start_cal(1'b0, s);
    bad = 1'b0;
    ticks(LOW_CYC + 2);
    for (int i = 0; i < 10000; i++) begin
      if (dcc_req !== 1'b1 || cal_busy !== 1'b1 || cal_err !== 1'b0) bad = 1'b1;
      tick();
    end
    checks++;
    if (bad || req_fall.size() !== 0) begin
      errors++; $display("FAIL timeout_zero: req=%b busy=%b falls=%0d want 1 1 0", dcc_req, cal_busy, req_fall.size());
    end
  endtask

  task automatic test_reset_mid();
    int s;
    bit ok;
    stop_cal();
    timeout_val = TO_W'(5);
    clear_log();
    start_cal(1'b0, s);
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      ok = (retry_cnt === RW'(2)) && (dcc_req === 1'b1);
      if (!ok) tick();
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (!ok || {dcc_req, cal_done, cal_err, cal_busy, lock_lost, retry_cnt} !== 7'b0) begin
      errors++; $display("FAIL reset_mid: reached=%0d got %b want 0", ok,
                         {dcc_req, cal_done, cal_err, cal_busy, lock_lost, retry_cnt});
    end
    tick();
    rst_n = 1'b1;
    ticks(2);
  endtask

  task automatic test_stop_each_state();
    int s;
    bit ok;
    timeout_val = TO_W'(3);
    for (int st = 0; st < 5; st++) begin
      clear_log();
      if (st == 4) begin
        start_cal(1'b1, s);
      end else if (st > 0) begin
        if (st == 3) resp_q.push_back(2);
        start_cal(1'b0, s);
        case (st)
          1: ticks(3);
          2: wait_for(2, 50, ok);
          default: wait_for(st == 3 ? 0 : 1, 100, ok);
        endcase
        if (st == 3) timeout_val = TO_W'(3);
      end
      cal_stop = 1'b1;
      tick();
      cal_stop = 1'b0;
      checks++;
      if ({dcc_req, cal_done, cal_err, cal_busy} !== 4'b0) begin
        errors++; $display("FAIL stop_state%0d: got %b want 0", st, {dcc_req, cal_done, cal_err, cal_busy});
      end
      resp_q.delete();
      ticks(3);
    end
    clear_log();
    start_cal(1'b0, s);
    wait_for(1, 100, ok);
    cal_stop = 1'b1;
    tick();
    cal_stop = 1'b0;
    checks++;
    if (!ok || cal_err !== 1'b0 || retry_cnt !== RW'(MAX_RETRY)) begin
      errors++; $display("FAIL stop_fail_hold: err=%b retry=%0d want 0 %0d", cal_err, retry_cnt, MAX_RETRY);
    end
    cal_start = 1'b1;
    cal_stop  = 1'b1;
    tick();
    checks++;
    if (cal_busy !== 1'b0) begin errors++; $display("FAIL stop_priority: busy=%b want 0", cal_busy); end
    cal_stop = 1'b0;
    tick();
    cal_start = 1'b0;
    checks++;
    if (cal_busy !== 1'b1 || retry_cnt !== RW'(0)) begin
      errors++; $display("FAIL held_start_restart: busy=%b retry=%0d want 1 0", cal_busy, retry_cnt);
    end
    stop_cal();
  endtask

  initial begin
    test_reset();
    test_normal_lock();
    test_retry_then_lock();
    test_exhaustion();
    test_same_cycle();
    test_lost_lock_bypass();
    test_timeout_zero();
    test_reset_mid();
    test_stop_each_state();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
